// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stage enables/flushes, EX forwarding
// selects, data-memory wait FSM with timeout watchdog, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic mstall_s, luse_s, redirect_take_s;
  logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s, ex_mem_en_s, bubble_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // x0 is hardwired zero, so it is never forwarded; MEM is younger than WB and wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] mrd,
                                         input logic mw, input logic [4:0] wrd, input logic ww);
    logic [1:0] sel;
    if (rs == 5'd0) begin
      sel = 2'b00;
    end else if (mw && (mrd == rs)) begin
      sel = 2'b10;
    end else if (ww && (wrd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign mstall_s = mem_req_i & ~dmem_ready_i;
  assign luse_s   = ex_mem_read_i & (ex_rd_i != 5'd0) &
                    ((id_uses_rs1_i & (ex_rd_i == id_rs1_i)) |
                     (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));
  assign fwd_a_s  = fwd_sel(ex_rs1_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
  assign fwd_b_s  = fwd_sel(ex_rs2_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mstall_s) begin
          state_d = ST_WAIT;
          wcnt_d  = TO_ONE;
        end else begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        if (!mstall_s) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == TO_LIM) begin
          state_d = ST_ERR;
          wcnt_d  = wcnt_q;
        end else begin
          state_d = ST_WAIT;
          wcnt_d  = wcnt_q + TO_ONE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
        wcnt_d  = wcnt_q;
      end
      default: begin
        state_d = ST_ERR;
        wcnt_d  = wcnt_q;
      end
    endcase
  end

  // Priority ERR > mstall > redirect > load-use > normal; ungated by reset so no flop sees rst_ni as data.
  always_comb begin
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_en_s      = 1'b1;
    id_ex_flush_s   = 1'b0;
    ex_mem_en_s     = 1'b1;
    bubble_s        = 1'b0;
    redirect_take_s = 1'b0;
    if ((state_q != ST_RUN) && (state_q != ST_WAIT)) begin
      pc_en_s     = 1'b0;
      if_id_en_s  = 1'b0;
      id_ex_en_s  = 1'b0;
      ex_mem_en_s = 1'b0;
      bubble_s    = 1'b1;
    end else if (mstall_s) begin
      pc_en_s     = 1'b0;
      if_id_en_s  = 1'b0;
      id_ex_en_s  = 1'b0;
      ex_mem_en_s = 1'b0;
      bubble_s    = 1'b1;
    end else if (ex_redirect_i) begin
      if_id_flush_s   = 1'b1;
      id_ex_flush_s   = 1'b1;
      redirect_take_s = 1'b1;
    end else if (luse_s) begin
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      id_ex_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  always_comb begin
    if (!rst_ni) begin
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_en_o      = 1'b0;
      id_ex_flush_o   = 1'b1;
      ex_mem_en_o     = 1'b0;
      mem_wb_bubble_o = 1'b1;
      fwd_a_o         = 2'b00;
      fwd_b_o         = 2'b00;
    end else begin
      pc_en_o         = pc_en_s;
      if_id_en_o      = if_id_en_s;
      if_id_flush_o   = if_id_flush_s;
      id_ex_en_o      = id_ex_en_s;
      id_ex_flush_o   = id_ex_flush_s;
      ex_mem_en_o     = ex_mem_en_s;
      mem_wb_bubble_o = bubble_s;
      fwd_a_o         = fwd_a_s;
      fwd_b_o         = fwd_b_s;
    end
  end

  // Saturating counters and sticky error flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_take_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    err_d = (state_d == ST_ERR);
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
